// File: rtl/prog_mem_loader_pkg.sv
// prog_mem_loader_pkg
// Shared definitions for the PicoBlaze program loader: FSM state encoding,
// frame sync byte, instruction width and the field layout of the first
// instruction byte (B0).
package prog_mem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         INSTR_W   = 18;

  // B0 carries instr[17:16] in its low two bits; the upper six must be zero.
  localparam int B0_INSTR_MSB = 1;
  localparam int B0_INSTR_LSB = 0;
  localparam int B0_PAD_MSB   = 7;
  localparam int B0_PAD_LSB   = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_B0,
    ST_B1,
    ST_B2,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/prog_mem_loader_chksum.sv
// prog_mem_loader_chksum
// Mod-256 byte accumulator used to verify the frame trailer byte.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the accumulator (takes priority over add)
//   add        : add data into the running sum
//   data       : byte to accumulate
//   sum        : current mod-256 sum
module prog_mem_loader_chksum (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       add,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sum <= '0;
    end else if (add) begin
      sum <= sum + data;
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// prog_mem_loader
// Receives a framed byte stream (0xA5, LEN_HI, LEN_LO, then 3 bytes per
// 18-bit instruction) and writes the instructions to addresses 0..N-1 of the
// program memory's write port, holding the CPU in reset while loading.
// Optional feature macro: PROG_MEM_LOADER_CHECKSUM_EN adds a trailing
// mod-256 checksum byte (sum of LEN_HI, LEN_LO and all data bytes).
//
// Handshake: a byte is consumed on every clock edge where rx_valid and
// rx_ready are both high; rx_ready is a register, so it never depends
// combinationally on rx_valid.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : load request, honoured in IDLE and ERR only
//   rx_data, rx_valid   : incoming byte stream
//   rx_ready            : loader consumes a byte this cycle
//   mem_addr, mem_din   : write address / instruction word
//   mem_we              : one-cycle write strobe
//   cpu_reset           : holds the processor in reset during a load
//   busy, done, error   : status (done is a one-cycle pulse)
//   fsm_state           : current FSM state, for observation
module prog_mem_loader
  import prog_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_din,
  output logic               mem_we,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               error,
  output state_t             fsm_state
);

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [1:0]  b0_bits;
  logic [7:0]  b1;
  logic [15:0] wcnt;

  logic        accept;
  logic        start_take;
  logic [15:0] len_rx;
  logic        len_ok;
  logic        last_word;

  assign accept     = rx_valid && rx_ready;
  assign start_take = (state == ST_IDLE || state == ST_ERR) && start;
  assign len_rx     = {len_hi, rx_data};
  assign len_ok     = (len_rx != 16'd0) && ({1'b0, len_rx} <= DEPTH_L);
  assign last_word  = (wcnt + 16'd1) == len;
  assign fsm_state  = state;

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
  logic [7:0] chk_sum;
  logic       chk_add;

  assign chk_add = accept && (state inside {ST_LEN_HI, ST_LEN_LO, ST_B0, ST_B1, ST_B2});

  prog_mem_loader_chksum u_chksum (
    .clk   (clk),
    .reset (reset),
    .clear (start_take),
    .add   (chk_add),
    .data  (rx_data),
    .sum   (chk_sum)
  );
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SYNC;
      // Bytes other than the sync byte are dropped so the loader can lock
      // onto a frame even if it starts mid-stream.
      ST_SYNC:   if (accept && rx_data == SYNC_BYTE) state_nxt = ST_LEN_HI;
      ST_LEN_HI: if (accept) state_nxt = ST_LEN_LO;
      ST_LEN_LO: if (accept) state_nxt = len_ok ? ST_B0 : ST_ERR;
      ST_B0: begin
        if (accept) begin
          state_nxt = (rx_data[B0_PAD_MSB:B0_PAD_LSB] != '0) ? ST_ERR : ST_B1;
        end
      end
      ST_B1:     if (accept) state_nxt = ST_B2;
      ST_B2:     if (accept) state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (last_word) begin
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_DONE;
`endif
        end else begin
          state_nxt = ST_B0;
        end
      end
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
      ST_CHECK:  if (accept) state_nxt = (rx_data == chk_sum) ? ST_DONE : ST_ERR;
`endif
      ST_DONE:   state_nxt = ST_IDLE;
      ST_ERR:    if (start) state_nxt = ST_SYNC;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // All outputs are decoded from the next state so they line up with the
  // state register and come straight out of flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
      cpu_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      len_hi    <= '0;
      len       <= '0;
      b0_bits   <= '0;
      b1        <= '0;
      wcnt      <= '0;
    end else begin
      state     <= state_nxt;
      rx_ready  <= state_nxt inside {ST_SYNC, ST_LEN_HI, ST_LEN_LO,
                                     ST_B0, ST_B1, ST_B2, ST_CHECK};
      mem_we    <= (state_nxt == ST_WRITE);
      cpu_reset <= !(state_nxt inside {ST_IDLE, ST_DONE});
      busy      <= !(state_nxt inside {ST_IDLE, ST_DONE, ST_ERR});
      done      <= (state_nxt == ST_DONE);
      error     <= (state_nxt == ST_ERR);

      if (start_take) begin
        wcnt <= '0;
      end else if (state == ST_WRITE) begin
        wcnt <= wcnt + 16'd1;
      end

      if (accept) begin
        case (state)
          ST_LEN_HI: len_hi <= rx_data;
          ST_LEN_LO: len    <= len_rx;
          ST_B0:     b0_bits <= rx_data[B0_INSTR_MSB:B0_INSTR_LSB];
          ST_B1:     b1     <= rx_data;
          // Address and data are loaded together so they are stable for the
          // whole WRITE cycle that follows.
          ST_B2: begin
            mem_din  <= {b0_bits, b1, rx_data};
            mem_addr <= wcnt[ADDR_W-1:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader
// Directed bench for prog_mem_loader: frame loads, sync hunting, length and
// B0 format errors, recovery, and reset in the middle of a load.
module tb_prog_mem_loader;
  import prog_mem_loader_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
  localparam int CHK_EXTRA = 1;
`else
  localparam int CHK_EXTRA = 0;
`endif

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [17:0]       mem_din;
  logic              mem_we;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;
  state_t            fsm_state;

  always #5 clk = ~clk;

  prog_mem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .fsm_state (fsm_state)
  );

  // Program memory write port model and activity monitors.
  logic [17:0] pmem [DEPTH];
  int cyc      = 0;
  int we_count = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) pmem[mem_addr] <= mem_din;
  end

  always @(negedge clk) begin
    if (mem_we) we_count++;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  logic [17:0] wbuf [8];
  logic [7:0]  exp_sum;
  logic [7:0]  chk_bias = 8'd0;

  // Called and returns at a negedge; the byte is consumed on the posedge
  // in between.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
  endtask

  task automatic pulse_start(output int t);
    t     = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_load(input int n);
    logic [15:0] nl;
    logic [7:0]  b;
    nl      = 16'(n);
    exp_sum = nl[15:8] + nl[7:0];
    send_byte(8'hA5);
    send_byte(nl[15:8]);
    send_byte(nl[7:0]);
    for (int i = 0; i < n; i++) begin
      b = {6'd0, wbuf[i][17:16]}; exp_sum += b; send_byte(b);
      b = wbuf[i][15:8];          exp_sum += b; send_byte(b);
      b = wbuf[i][7:0];           exp_sum += b; send_byte(b);
    end
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    send_byte(exp_sum + chk_bias);
`endif
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(output int t);
    int guard = 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    t = cyc;
  endtask

  // ---------------- stimulus ----------------
  int t_start, t_done, w0;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) pmem[i] = '0;
    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
    repeat (3) @(negedge clk);

    check("rst_state",     32'(fsm_state), 32'(ST_IDLE));
    check("rst_rx_ready",  {31'd0, rx_ready}, 32'd0);
    check("rst_mem_we",    {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr",  32'(mem_addr), 32'd0);
    check("rst_mem_din",   32'(mem_din), 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_done",      {31'd0, done}, 32'd0);
    check("rst_error",     {31'd0, error}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // N=2 full-speed load
    wbuf[0] = 18'h2_0F3F; wbuf[1] = 18'h0_0D00;
    w0 = we_count;
    pulse_start(t_start);
    check("n2_cpu_reset_rise", {31'd0, cpu_reset}, 32'd1);
    check("n2_busy",           {31'd0, busy}, 32'd1);
    send_load(2);
    wait_done(t_done);
    check("n2_done_latency",   32'(t_done - t_start), 32'(12 + CHK_EXTRA));
    check("n2_cpu_reset_done", {31'd0, cpu_reset}, 32'd0);
    check("n2_busy_done",      {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("n2_done_pulse",     {31'd0, done}, 32'd0);
    check("n2_cpu_reset_after",{31'd0, cpu_reset}, 32'd0);
    check("n2_we_count",       32'(we_count - w0), 32'd2);
    check("n2_mem0",           32'(pmem[0]), 32'h2_0F3F);
    check("n2_mem1",           32'(pmem[1]), 32'h0_0D00);

    // Garbage before sync is discarded
    wbuf[0] = 18'h1_2345;
    w0 = we_count;
    pulse_start(t_start);
    send_byte(8'h00);
    send_byte(8'h13);
    send_load(1);
    wait_done(t_done);
    @(negedge clk);
    check("sync_we_count", 32'(we_count - w0), 32'd1);
    check("sync_mem0",     32'(pmem[0]), 32'h1_2345);

    // LEN = 0 -> ERR
    w0 = we_count;
    pulse_start(t_start);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    rx_valid = 1'b0;
    check("len0_error",     {31'd0, error}, 32'd1);
    check("len0_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("len0_busy",      {31'd0, busy}, 32'd0);
    check("len0_rx_ready",  {31'd0, rx_ready}, 32'd0);
    repeat (4) @(negedge clk);
    check("len0_error_hold", {31'd0, error}, 32'd1);
    check("len0_no_write",   32'(we_count - w0), 32'd0);

    // Recovery from ERR with start
    wbuf[0] = 18'h3_FFFF;
    w0 = we_count;
    pulse_start(t_start);
    check("recover_error", {31'd0, error}, 32'd0);
    check("recover_busy",  {31'd0, busy}, 32'd1);
    send_load(1);
    wait_done(t_done);
    @(negedge clk);
    check("recover_mem0",  32'(pmem[0]), 32'h3_FFFF);
    check("recover_we",    32'(we_count - w0), 32'd1);

    // LEN = 0x0401 (> DEPTH) -> ERR
    w0 = we_count;
    pulse_start(t_start);
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    rx_valid = 1'b0;
    check("len401_error",     {31'd0, error}, 32'd1);
    check("len401_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    repeat (3) @(negedge clk);
    check("len401_no_write",  32'(we_count - w0), 32'd0);

    // B0 with nonzero pad bits -> ERR (started from ERR)
    w0 = we_count;
    pulse_start(t_start);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h04);
    rx_valid = 1'b0;
    check("b0_error",     {31'd0, error}, 32'd1);
    check("b0_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    repeat (3) @(negedge clk);
    check("b0_no_write",  32'(we_count - w0), 32'd0);
    reset = 1'b1; @(negedge clk); reset = 1'b0; @(negedge clk);
    check("b0_reset_clears", {31'd0, error}, 32'd0);

    // Reset after the 2nd word of N=5
    w0 = we_count;
    pulse_start(t_start);
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h02);
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_state",     32'(fsm_state), 32'(ST_IDLE));
    check("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("midrst_mem_we",    {31'd0, mem_we}, 32'd0);
    check("midrst_busy",      {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_we_count",  32'(we_count - w0), 32'd2);
    check("midrst_mem0",      32'(pmem[0]), 32'h1_0001);
    check("midrst_mem1",      32'(pmem[1]), 32'h2_0002);
    check("midrst_mem2",      32'(pmem[2]), 32'h0_0000);
    check("midrst_idle_stay", 32'(fsm_state), 32'(ST_IDLE));

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    // Wrong checksum byte -> ERR, CPU held in reset
    wbuf[0] = 18'h1_2345;
    chk_bias = 8'd1;
    pulse_start(t_start);
    send_load(1);
    repeat (2) @(negedge clk);
    check("chk_bad_error",     {31'd0, error}, 32'd1);
    check("chk_bad_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk_bias = 8'd0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
